// File: rtl/adc1align_pkg.sv
// Shared types and constants for the adc1align bit-line training sequencer.
// ADC1RCVD_WIDTH is the word width shared with the adc1rcvd receiver.
package adc1align_pkg;

  localparam int ADC1RCVD_WIDTH = 6;
  localparam int MAX_SLIPS      = 12;
  localparam int TAP_W          = 8;
  localparam int RUN_W          = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SRESET,
    ST_DRESET,
    ST_WAIT,
    ST_SCAN,
    ST_STEP,
    ST_CRST,
    ST_CINC,
    ST_SLIP,
    ST_CHECK,
    ST_FIN
  } state_t;

  // Floor centre of a run: start + len/2, computed at run width so it cannot wrap.
  function automatic logic [TAP_W-1:0] eye_centre(input logic [TAP_W-1:0] start,
                                                  input logic [RUN_W-1:0] len);
    logic [RUN_W-1:0] sum;
    sum = {1'b0, start} + (len >> 1);
    return sum[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/adc1align_if.sv
// Control/status bundle between adc1align and the channel logic.
// EYE_LO/EYE_HI exist only when ADC1ALIGN_EYEREPORT_EN is defined.
interface adc1align_if;
  import adc1align_pkg::*;

  logic                      START;
  logic [ADC1RCVD_WIDTH-1:0] DIN;
  logic                      SRST;
  logic                      DINC;
  logic                      DRST;
  logic                      BS;
  logic                      BUSY;
  logic                      DONE;
  logic                      FAIL;
  logic [TAP_W-1:0]          TAP;
`ifdef ADC1ALIGN_EYEREPORT_EN
  logic [TAP_W-1:0]          EYE_LO;
  logic [TAP_W-1:0]          EYE_HI;
`endif

  modport master (
    output START, DIN,
    input  SRST, DINC, DRST, BS, BUSY, DONE, FAIL, TAP
`ifdef ADC1ALIGN_EYEREPORT_EN
    , input EYE_LO, EYE_HI
`endif
  );

  modport slave (
    input  START, DIN,
    output SRST, DINC, DRST, BS, BUSY, DONE, FAIL, TAP
`ifdef ADC1ALIGN_EYEREPORT_EN
    , output EYE_LO, EYE_HI
`endif
  );

endinterface

// File: rtl/adc1align_eye.sv
// Stable-window tracker: follows the current run of good taps and keeps the best one.
// Eye bounds (ADC1ALIGN_EYEREPORT_EN) are taken from the committed best run.
module adc1align_eye
  import adc1align_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tap_good,
  input  logic             tap_bad,
  input  logic [TAP_W-1:0] tap,
  output logic [RUN_W-1:0] fin_len,
  output logic [TAP_W-1:0] centre
`ifdef ADC1ALIGN_EYEREPORT_EN
  ,
  output logic [TAP_W-1:0] eye_lo,
  output logic [TAP_W-1:0] eye_hi
`endif
);

  logic [TAP_W-1:0] cur_start;
  logic [RUN_W-1:0] cur_len;
  logic [TAP_W-1:0] best_start;
  logic [RUN_W-1:0] best_len;
  logic             take_cur;
  logic [TAP_W-1:0] fin_start;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (tap_good) begin
      if (cur_len == '0) cur_start <= tap;
      cur_len <= cur_len + 1'b1;
    end else if (tap_bad) begin
      // Strictly longer replaces; a tie keeps the earlier run.
      if (cur_len > best_len) begin
        best_start <= cur_start;
        best_len   <= cur_len;
      end
      cur_len <= '0;
    end
  end

  // Result as if the open run were closed now, so the caller can decide in one cycle.
  assign take_cur  = (cur_len > best_len);
  assign fin_start = take_cur ? cur_start : best_start;
  assign fin_len   = take_cur ? cur_len : best_len;
  assign centre    = eye_centre(fin_start, fin_len);

`ifdef ADC1ALIGN_EYEREPORT_EN
  assign eye_lo = best_start;
  assign eye_hi = best_start + best_len[TAP_W-1:0] - 1'b1;
`endif

endmodule

// File: rtl/adc1align.sv
// One-shot IODELAY/bitslip training sequencer for a single ADC bit line.
// Optional eye report outputs are enabled with ADC1ALIGN_EYEREPORT_EN.
module adc1align
  import adc1align_pkg::*;
#(
  parameter logic [ADC1RCVD_WIDTH-1:0] PATTERN = 6'b111000,
  parameter int NSAMP  = 64,
  parameter int MAXTAP = 63,
  parameter int SETTLE = 8,
  parameter int MINEYE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  adc1align_if.slave bus
);

  localparam int SCNT_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int WCNT_W = $clog2(SETTLE + 2);
  localparam logic [SCNT_W-1:0] LAST_SAMP   = SCNT_W'(NSAMP - 1);
  localparam logic [WCNT_W-1:0] SETTLE_L    = WCNT_W'(SETTLE);
  localparam logic [TAP_W-1:0]  MAX_TAP_L   = TAP_W'(MAXTAP);
  localparam logic [RUN_W-1:0]  MINEYE_L    = RUN_W'(MINEYE);
  localparam logic [3:0]        MAX_SLIPS_L = 4'(MAX_SLIPS);

  state_t                    state;
  state_t                    ret_state;
  logic [SCNT_W-1:0]         scnt;
  logic [WCNT_W-1:0]         wcnt;
  logic [3:0]                slips;
  logic [ADC1RCVD_WIDTH-1:0] ref_word_p0;
  logic                      good_p0;
  logic                      match_p0;
  logic [TAP_W-1:0]          tap_r;
  logic [TAP_W-1:0]          centre_r;
  logic                      srst_r, dinc_r, drst_r, bs_r;
  logic                      busy_r, done_r, fail_r;

  logic                      last_samp;
  logic                      scan_ok;
  logic                      check_ok;
  logic                      at_max;
  logic                      eye_clear;
  logic                      tap_good;
  logic                      tap_bad;
  logic [RUN_W-1:0]          fin_len;
  logic [TAP_W-1:0]          centre;
`ifdef ADC1ALIGN_EYEREPORT_EN
  logic [TAP_W-1:0]          eye_lo, eye_hi;
  logic [TAP_W-1:0]          eye_lo_r, eye_hi_r;
`endif

  assign last_samp = (scnt == LAST_SAMP);
  assign scan_ok   = (scnt == '0) || (good_p0 && (bus.DIN == ref_word_p0));
  assign check_ok  = ((scnt == '0) || match_p0) && (bus.DIN == PATTERN);
  assign at_max    = (tap_r == MAX_TAP_L);
  assign eye_clear = (state == ST_IDLE) && bus.START;
  assign tap_good  = (state == ST_SCAN) && last_samp && scan_ok;
  assign tap_bad   = ((state == ST_SCAN) && last_samp && !scan_ok) ||
                     ((state == ST_STEP) && at_max);

  adc1align_eye u_eye (
    .clk      (CLK),
    .rst      (RST),
    .clear    (eye_clear),
    .tap_good (tap_good),
    .tap_bad  (tap_bad),
    .tap      (tap_r),
    .fin_len  (fin_len),
    .centre   (centre)
`ifdef ADC1ALIGN_EYEREPORT_EN
    ,
    .eye_lo   (eye_lo),
    .eye_hi   (eye_hi)
`endif
  );

  // Sample registers carry no reset; they are always written before being read.
  always_ff @(posedge CLK) begin
    if (state == ST_SCAN) begin
      if (scnt == '0) ref_word_p0 <= bus.DIN;
      good_p0 <= scan_ok;
    end
    if (state == ST_CHECK) match_p0 <= check_ok;
  end

  // Every DINC/DRST/BS pulse is issued on entry to WAIT, which then holds SETTLE+1 cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      scnt      <= '0;
      wcnt      <= '0;
      slips     <= '0;
      tap_r     <= '0;
      centre_r  <= '0;
      srst_r    <= 1'b0;
      dinc_r    <= 1'b0;
      drst_r    <= 1'b0;
      bs_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      fail_r    <= 1'b0;
`ifdef ADC1ALIGN_EYEREPORT_EN
      eye_lo_r  <= '0;
      eye_hi_r  <= '0;
`endif
    end else begin
      dinc_r <= 1'b0;
      drst_r <= 1'b0;
      bs_r   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            done_r <= 1'b0;
            fail_r <= 1'b0;
            busy_r <= 1'b1;
            srst_r <= 1'b1;
            wcnt   <= '0;
`ifdef ADC1ALIGN_EYEREPORT_EN
            eye_lo_r <= '0;
            eye_hi_r <= '0;
`endif
            state  <= ST_SRESET;
          end
        end
        ST_SRESET: begin
          if (wcnt == WCNT_W'(1)) begin
            srst_r <= 1'b0;
            state  <= ST_DRESET;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_DRESET, ST_CRST: begin
          drst_r    <= 1'b1;
          tap_r     <= '0;
          wcnt      <= '0;
          ret_state <= (state == ST_DRESET) ? ST_SCAN : ST_CINC;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wcnt == SETTLE_L) begin
            wcnt  <= '0;
            scnt  <= '0;
            state <= ret_state;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_SCAN: begin
          scnt <= scnt + 1'b1;
          if (last_samp) state <= ST_STEP;
        end
        ST_STEP: begin
          if (at_max) begin
            if (fin_len < MINEYE_L) begin
              fail_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= ST_FIN;
            end else begin
              centre_r <= centre;
              state    <= ST_CRST;
            end
          end else begin
            dinc_r    <= 1'b1;
            tap_r     <= tap_r + 1'b1;
            wcnt      <= '0;
            ret_state <= ST_SCAN;
            state     <= ST_WAIT;
          end
        end
        ST_CINC: begin
          if (tap_r == centre_r) begin
            slips <= '0;
            scnt  <= '0;
            state <= ST_CHECK;
          end else begin
            dinc_r    <= 1'b1;
            tap_r     <= tap_r + 1'b1;
            wcnt      <= '0;
            ret_state <= ST_CINC;
            state     <= ST_WAIT;
          end
        end
        ST_CHECK: begin
          scnt <= scnt + 1'b1;
          if (last_samp) begin
            if (check_ok) begin
              done_r <= 1'b1;
              busy_r <= 1'b0;
`ifdef ADC1ALIGN_EYEREPORT_EN
              eye_lo_r <= eye_lo;
              eye_hi_r <= eye_hi;
`endif
              state  <= ST_FIN;
            end else if (slips < MAX_SLIPS_L) begin
              state <= ST_SLIP;
            end else begin
              fail_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= ST_FIN;
            end
          end
        end
        ST_SLIP: begin
          bs_r      <= 1'b1;
          slips     <= slips + 1'b1;
          wcnt      <= '0;
          ret_state <= ST_CHECK;
          state     <= ST_WAIT;
        end
        ST_FIN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SRST = srst_r;
  assign bus.DINC = dinc_r;
  assign bus.DRST = drst_r;
  assign bus.BS   = bs_r;
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;
  assign bus.FAIL = fail_r;
  assign bus.TAP  = tap_r;
`ifdef ADC1ALIGN_EYEREPORT_EN
  assign bus.EYE_LO = eye_lo_r;
  assign bus.EYE_HI = eye_hi_r;
`endif

endmodule
